// File: rtl/instruction_rom_loader_if.sv
// ---------------------------------------------------------------------------
// instruction_rom_loader_if
//   Bundles the two traffic paths of the reloadable instruction memory:
//     - CPU fetch port : fetch_addr (in), fetch_instruction (out)
//     - byte loader    : load_start, load_valid, load_data, load_last (in),
//                        load_ready (out)
//   master : the side that drives addresses and program bytes (CPU/UART)
//   slave  : the instruction memory itself
// ---------------------------------------------------------------------------
interface instruction_rom_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16
);
  logic [PC_WIDTH-1:0]   fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_instruction;
  logic                  load_start;
  logic                  load_valid;
  logic [7:0]            load_data;
  logic                  load_last;
  logic                  load_ready;

  modport master (
    output fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_instruction, load_ready
  );

  modport slave (
    input  fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_instruction, load_ready
  );
endinterface

// File: rtl/instruction_rom_loader.sv
// ---------------------------------------------------------------------------
// instruction_rom_loader
//   Run-time reloadable instruction memory for the Hack computer. A program
//   image arrives as a byte stream (MSB of each word first) and is written
//   word by word into a block RAM; while loading, the CPU is held in reset
//   and the fetch output is forced to zero.
//
//   Ports:
//     clk          system clock
//     reset        asynchronous, active-low reset
//     bus          slave side of instruction_rom_loader_if (fetch + loader)
//     cpu_hold     to the CPU reset input, 1 while a load is in progress
//     words_loaded words written by the current / last load
//     load_error   sticky: overflow or image ended mid-word
// ---------------------------------------------------------------------------
module instruction_rom_loader #(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 12,
  parameter int DEPTH            = 4096,
  parameter int PC_WIDTH         = 16,
  parameter bit FETCH_ON_NEGEDGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_rom_loader_if.slave bus,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  load_error
);

  localparam int                BYTES     = DATA_WIDTH / 8;
  localparam int                BCNT_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  // Range check is done wide enough that no fetch_addr bit is ever dropped.
  localparam int                CMP_W     = (PC_WIDTH > 32) ? PC_WIDTH + 1 : 33;

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FINISH} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [BCNT_W-1:0]       byte_cnt;
  logic [DATA_WIDTH-1:0]   word_next;
  logic [DATA_WIDTH-1:0]   fetch_next;
  logic [DATA_WIDTH-1:0]   fetch_q;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    accept;
  logic                    last_byte;
  logic                    full;
  logic                    do_write;
  logic                    in_range;

  assign accept    = bus.load_valid && (state == ST_LOAD);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign full      = (words_loaded == DEPTH_W);
  assign do_write  = accept && last_byte && !full;

  // --------------------------------------------------------------- FSM
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    cpu_hold       = 1'b1;
    bus.load_ready = 1'b0;
    case (state)
      ST_RUN: begin
        cpu_hold = 1'b0;
        if (bus.load_start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        bus.load_ready = 1'b1;
        if (accept && bus.load_last) state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  // ---------------------------------------------------- word assembly
  // Bytes shift in MSB first; the completed word is {earlier bytes, new byte}.
  if (DATA_WIDTH > 8) begin : g_asm
    logic [DATA_WIDTH-9:0] assembly;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)      assembly <= '0;
      else if (accept) assembly <= word_next[DATA_WIDTH-9:0];
    end
    assign word_next = {assembly, bus.load_data};
  end else begin : g_no_asm
    assign word_next = bus.load_data;
  end

  // ------------------------------------------------- load bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      byte_cnt     <= '0;
      words_loaded <= '0;
      load_error   <= 1'b0;
    end else if (state == ST_RUN && bus.load_start) begin
      wr_ptr       <= '0;
      byte_cnt     <= '0;
      words_loaded <= '0;
      load_error   <= 1'b0;
    end else if (accept) begin
      if (last_byte) begin
        byte_cnt <= '0;
        if (full) begin
          // Image larger than the memory: drop the word, keep the counters.
          load_error <= 1'b1;
        end else begin
          wr_ptr       <= wr_ptr + ADDR_WIDTH'(1);
          words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
        end
      end else if (bus.load_last) begin
        // Image ended mid-word: the partial word is discarded.
        byte_cnt   <= '0;
        load_error <= 1'b1;
      end else begin
        byte_cnt <= byte_cnt + BCNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------------ memory
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; its contents
  // survive both reset and an aborted load.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= word_next;
  end

  // ------------------------------------------------------------- fetch
  assign rd_addr    = ADDR_WIDTH'(bus.fetch_addr);
  assign in_range   = CMP_W'(bus.fetch_addr) < CMP_W'(DEPTH);
  assign fetch_next = (cpu_hold || !in_range) ? '0 : mem[rd_addr];

  // Falling-edge capture gives the CPU its instruction half a cycle after
  // it presents the PC, matching the original single-cycle ROM timing.
  if (FETCH_ON_NEGEDGE) begin : g_fetch_neg
    always_ff @(negedge clk or negedge reset) begin
      if (!reset) fetch_q <= '0;
      else        fetch_q <= fetch_next;
    end
  end else begin : g_fetch_pos
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) fetch_q <= '0;
      else        fetch_q <= fetch_next;
    end
  end

  assign bus.fetch_instruction = fetch_q;

endmodule

// File: tb/tb_instruction_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_instruction_rom_loader
//   Three instances share one stimulus stream:
//     d0 : DEPTH=4096, falling-edge fetch
//     d1 : DEPTH=4 (ADDR_WIDTH=2), falling-edge fetch
//     d2 : DEPTH=4096, rising-edge fetch
//   Fetch expectations go into a queue when an address is driven and are
//   popped when each instance's capture edge has passed.
// ---------------------------------------------------------------------------
module tb_instruction_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fetch_addr;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_data;

  logic        hold_w  [3];
  logic        ready_w [3];
  logic        err_w   [3];
  logic [15:0] fetch_w [3];
  logic [12:0] words_w [3];
  logic [12:0] words_0, words_2;
  logic [2:0]  words_1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          dut;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  img [16];
  bit          lat_ok;
  logic [15:0] last_c_exp;

  always #5 clk = ~clk;

  instruction_rom_loader_if #(.DATA_WIDTH(16), .PC_WIDTH(16)) bus0 ();
  instruction_rom_loader_if #(.DATA_WIDTH(16), .PC_WIDTH(16)) bus1 ();
  instruction_rom_loader_if #(.DATA_WIDTH(16), .PC_WIDTH(16)) bus2 ();

  assign bus0.fetch_addr = fetch_addr;  assign bus1.fetch_addr = fetch_addr;  assign bus2.fetch_addr = fetch_addr;
  assign bus0.load_start = load_start;  assign bus1.load_start = load_start;  assign bus2.load_start = load_start;
  assign bus0.load_valid = load_valid;  assign bus1.load_valid = load_valid;  assign bus2.load_valid = load_valid;
  assign bus0.load_data  = load_data;   assign bus1.load_data  = load_data;   assign bus2.load_data  = load_data;
  assign bus0.load_last  = load_last;   assign bus1.load_last  = load_last;   assign bus2.load_last  = load_last;

  assign fetch_w[0] = bus0.fetch_instruction;  assign ready_w[0] = bus0.load_ready;
  assign fetch_w[1] = bus1.fetch_instruction;  assign ready_w[1] = bus1.load_ready;
  assign fetch_w[2] = bus2.fetch_instruction;  assign ready_w[2] = bus2.load_ready;
  assign words_w[0] = words_0;
  assign words_w[1] = {10'b0, words_1};
  assign words_w[2] = words_2;

  instruction_rom_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(4096), .PC_WIDTH(16),
                           .FETCH_ON_NEGEDGE(1'b1)) d0 (
    .clk(clk), .reset(rst_n), .bus(bus0.slave),
    .cpu_hold(hold_w[0]), .words_loaded(words_0), .load_error(err_w[0]));

  instruction_rom_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .DEPTH(4), .PC_WIDTH(16),
                           .FETCH_ON_NEGEDGE(1'b1)) d1 (
    .clk(clk), .reset(rst_n), .bus(bus1.slave),
    .cpu_hold(hold_w[1]), .words_loaded(words_1), .load_error(err_w[1]));

  instruction_rom_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(4096), .PC_WIDTH(16),
                           .FETCH_ON_NEGEDGE(1'b0)) d2 (
    .clk(clk), .reset(rst_n), .bus(bus2.slave),
    .cpu_hold(hold_w[2]), .words_loaded(words_2), .load_error(err_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic hold, input logic ready);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_hold_d%0d", tag, d), 32'(hold_w[d]), 32'(hold));
      check($sformatf("%s_ready_d%0d", tag, d), 32'(ready_w[d]), 32'(ready));
    end
  endtask

  task automatic check_counts(input string tag, input int w0, input int w1, input int w2,
                              input logic e0, input logic e1, input logic e2);
    check({tag, "_words_d0"}, 32'(words_w[0]), w0);
    check({tag, "_words_d1"}, 32'(words_w[1]), w1);
    check({tag, "_words_d2"}, 32'(words_w[2]), w2);
    check({tag, "_err_d0"}, 32'(err_w[0]), 32'(e0));
    check({tag, "_err_d1"}, 32'(err_w[1]), 32'(e1));
    check({tag, "_err_d2"}, 32'(err_w[2]), 32'(e2));
  endtask

  task automatic pop_check(input logic [15:0] addr);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("fetch_%h_d%0d", addr, e.dut), 32'(fetch_w[e.dut]), 32'(e.data));
    end
  endtask

  // Drive a PC; d0/d1 must show the word after the next falling edge, d2 must
  // still show its previous word then and the new one after the rising edge.
  task automatic fetch(input logic [15:0] addr, input logic [15:0] e0,
                       input logic [15:0] e1, input logic [15:0] e2);
    @(posedge clk); #1;
    fetch_addr = addr;
    exp_q.push_back('{0, e0});
    exp_q.push_back('{1, e1});
    exp_q.push_back('{2, e2});
    @(negedge clk); #1;
    pop_check(addr);
    pop_check(addr);
    if (lat_ok) check($sformatf("latency_%h_d2", addr), 32'(fetch_w[2]), 32'(last_c_exp));
    @(posedge clk); #1;
    pop_check(addr);
    last_c_exp = e2;
    lat_ok     = 1'b1;
  endtask

  task automatic start_load();
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Stream img[0..n-1], load_last on the final byte; gaps inserts an idle
  // cycle (with junk data and load_last high) before every byte.
  task automatic load_image(input int n, input bit gaps);
    start_load();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        load_valid = 1'b0;
        load_data  = 8'hFF;
        load_last  = 1'b1;
        @(posedge clk); #1;
      end
      check_ctrl($sformatf("load_b%0d", i), 1'b1, 1'b1);
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = (i == n - 1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check_ctrl("finish", 1'b1, 1'b0);
    for (int d = 0; d < 3; d++)
      check($sformatf("finish_fetch_d%0d", d), 32'(fetch_w[d]), 0);
    @(posedge clk); #1;
    check_ctrl("run", 1'b0, 1'b0);
    lat_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    lat_ok     = 1'b0;
    last_c_exp = '0;

    // ---- reset
    repeat (3) @(posedge clk);
    #1;
    check_ctrl("reset", 1'b0, 1'b0);
    check_counts("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_fetch_d%0d", d), 32'(fetch_w[d]), 0);
    rst_n = 1'b1;

    // ---- basic two-word load
    img[0] = 8'h00; img[1] = 8'h07; img[2] = 8'hEC; img[3] = 8'h10;
    load_image(4, 1'b0);
    check_counts("basic", 2, 2, 2, 1'b0, 1'b0, 1'b0);
    fetch(16'h0000, 16'h0007, 16'h0007, 16'h0007);
    fetch(16'h0001, 16'hEC10, 16'hEC10, 16'hEC10);

    // ---- idle gaps between bytes (fresh data so a stale word shows up)
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78;
    load_image(4, 1'b1);
    check_counts("gaps", 2, 2, 2, 1'b0, 1'b0, 1'b0);
    fetch(16'h0000, 16'h1234, 16'h1234, 16'h1234);
    fetch(16'h0001, 16'h5678, 16'h5678, 16'h5678);

    // ---- five words: overflows d1 (DEPTH=4) only
    for (int w = 0; w < 5; w++) begin
      img[2*w]   = 8'hA0 + 8'(w);
      img[2*w+1] = 8'(w + 1);
    end
    load_image(10, 1'b0);
    check_counts("overflow", 5, 4, 5, 1'b0, 1'b1, 1'b0);
    fetch(16'h0000, 16'hA001, 16'hA001, 16'hA001);
    fetch(16'h0001, 16'hA102, 16'hA102, 16'hA102);
    fetch(16'h0002, 16'hA203, 16'hA203, 16'hA203);
    fetch(16'h0003, 16'hA304, 16'hA304, 16'hA304);
    fetch(16'h0004, 16'hA405, 16'h0000, 16'hA405);
    fetch(16'h1000, 16'h0000, 16'h0000, 16'h0000);
    fetch(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);

    // ---- load_last on the 3rd byte: word 1 must keep its old contents
    img[0] = 8'hBE; img[1] = 8'hEF; img[2] = 8'hCA;
    load_image(3, 1'b0);
    check_counts("midword", 1, 1, 1, 1'b1, 1'b1, 1'b1);
    fetch(16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    fetch(16'h0001, 16'hA102, 16'hA102, 16'hA102);

    // ---- reset during a 3-word load, after one word and one extra byte
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33;
    start_load();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = img[i];
      @(posedge clk); #1;
    end
    check_counts("abort_pre", 1, 1, 1, 1'b0, 1'b0, 1'b0);
    rst_n      = 1'b0;
    load_valid = 1'b0;
    #1;
    check_ctrl("abort", 1'b0, 1'b0);
    check_counts("abort", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++)
      check($sformatf("abort_fetch_d%0d", d), 32'(fetch_w[d]), 0);
    lat_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch(16'h0000, 16'h1122, 16'h1122, 16'h1122);
    fetch(16'h0001, 16'hA102, 16'hA102, 16'hA102);
    fetch(16'h0002, 16'hA203, 16'hA203, 16'hA203);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_rom_loader.md
Name: instruction_rom_loader

Overview:
- Parametrised instruction memory for the Hack computer.
- Can be reprogrammed at run time from a byte-stream port (e.g. UART receiver) without resynthesis.
- Serves the CPU fetch port (address in, instruction out) and holds the CPU in reset while a program is being loaded.
- Sits between the computer top level's program-PC output and the CPU instruction input; replaces the fixed 4096-word ROM array.

Parameters:
- DATA_WIDTH, 16: instruction width; must be a multiple of 8.
- ADDR_WIDTH, 12: internal memory address width.
- DEPTH, 4096: number of instruction words; DEPTH <= 2**ADDR_WIDTH.
- PC_WIDTH, 16: width of fetch_addr driven by the CPU.
- FETCH_ON_NEGEDGE, 1:
  - 1 = fetch register captures on falling clk edge (half-cycle latency).
  - 0 = captures on rising edge (one-cycle latency).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- fetch_addr  input  PC_WIDTH  next PC from the CPU
- fetch_instruction  output  DATA_WIDTH  registered instruction word
- load_start  input  1  single-cycle request to begin a program load
- load_valid  input  1  load_data holds a valid byte
- load_data  input  8  program byte, most-significant byte of each word first
- load_last  input  1  qualifies the final byte of the image
- load_ready  output  1  block accepts a byte this cycle
- cpu_hold  output  1  drive to the CPU reset input; 1 while loading
- words_loaded  output  ADDR_WIDTH+1  words written in the current or last load
- load_error  output  1  sticky error for the current or last load

Behaviour:
- Reset (reset=0, asynchronous), all at once:
  - state=RUN, cpu_hold=0, load_ready=0, fetch_instruction=0, words_loaded=0, load_error=0, write pointer=0, byte counter=0.
  - Memory contents are not cleared.
- States: RUN, LOAD, FINISH.
- RUN:
  - cpu_hold=0, load_ready=0.
  - load_start=1 -> LOAD on the next rising edge. On that edge: cpu_hold=1, write pointer=0, byte counter=0, words_loaded=0, load_error=0.
- LOAD:
  - load_ready=1; a byte is accepted when load_valid & load_ready at a rising edge.
  - Bytes shift into a DATA_WIDTH assembly register MSB-first. The byte counter counts 0..DATA_WIDTH/8-1.
  - On acceptance of the last byte of a word:
    - write {assembly, byte} to mem[write pointer];
    - pointer+1 and words_loaded+1, both visible the next cycle.
  - Overflow: if a word completes while words_loaded==DEPTH, the write is suppressed, load_error=1, and counters are unchanged.
  - load_last accepted with the final byte of a word -> FINISH.
  - load_last accepted mid-word -> partial word discarded, load_error=1 -> FINISH.
  - load_start is ignored outside RUN.
- FINISH:
  - Lasts exactly one cycle, with cpu_hold=1 and load_ready=0.
  - Then RUN with cpu_hold=0, so the CPU leaves reset fetching address 0.
- Fetch:
  - Capture edge is selected by FETCH_ON_NEGEDGE.
  - fetch_instruction <= mem[fetch_addr] when fetch_addr < DEPTH, otherwise 0.
  - While cpu_hold=1, fetch_instruction <= 0.
  - Unused upper fetch_addr bits count for the range check and are never truncated.
- Read/write to the same address in one cycle: the read returns old data. This is irrelevant in practice because the output is forced to 0 during a hold.
- Reset mid-load: immediate return to RUN with cpu_hold=0. Already-written words are retained; the remainder of memory keeps its prior contents.
- words_loaded and load_error hold their values after FINISH until the next load_start or reset.
- Memory must infer block RAM: synchronous write, registered read, no reset on the array.

Test Plan:
1. Reset low for 3 cycles, then high -> fetch_instruction=0, cpu_hold=0, load_ready=0, words_loaded=0, load_error=0.
2. load_start pulse, then bytes 0x00,0x07,0xEC,0x10 with load_last on the 4th -> cpu_hold=1 throughout, then 1 cycle of FINISH, then cpu_hold=0; words_loaded=2. Fetch addr 0 -> 0x0007, addr 1 -> 0xEC10, each checked at the configured edge.
3. Load with load_valid toggling every other cycle (back-pressure-free gaps) -> same result as scenario 2; no byte is dropped or duplicated.
4. DEPTH=4: stream 5 words with load_last on the 10th byte -> words_loaded=4, load_error=1, mem[0..3] equal the first 4 words.
5. load_last asserted on the 3rd byte (mid-word) -> words_loaded=1, load_error=1, second word not written, return to RUN.
6. Assert reset after 1 word of a 3-word load -> cpu_hold=0 immediately, fetch addr 0 returns the new word. Separately, fetch_addr=0x1000 with DEPTH=4096 -> 0x0000. Repeat scenarios 2 and 6 with FETCH_ON_NEGEDGE=0 and check one-cycle latency.
